// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter.
// REG_COUNT/REG_ADDR_W describe the 8-entry register file, REQ_EXE/REQ_LD
// name the two requesters by their grant bit index, R0 is register zero.
package rf_pkg;

  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = 3;

  localparam logic REQ_EXE = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  localparam logic [REG_ADDR_W-1:0] R0 = 3'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (priority back to requester 0)
//   req_i    request vector, bit k = requester k
//   enable_i 0 = grant nothing and freeze the priority pointer
//   grant_o  one-hot grant, or zero when nothing is granted
// A lone requester always wins; on contention the pointer decides, and the
// pointer then favours the requester that lost.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  logic prio_q;
  logic prio_d;

  // Grant selection and next priority pointer
  always_comb begin
    grant_o = 2'b00;
    prio_d  = prio_q;
    if (enable_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end else begin
      grant_o = 2'b00;
    end
    // The winner gives up priority to the other requester
    if (grant_o[0]) begin
      prio_d = 1'b1;
    end else if (grant_o[1]) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges the execute-unit (req0) and load-unit (req1)
// write streams onto the single register-file write port.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   stall_i                       1 = grant nothing this cycle
//   reqN_valid/dest/data/ready    valid/ready write request from requester N
//   regWrite_o/destReg_o/writeData_o  registered register-file write port
//   grant_id_o                    requester behind the current write/drop
//   dropped_o                     pulse: accepted write to R0 suppressed
// Readies are combinational from valid; the accepted write shows up on the
// write port one cycle later.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int W_width = 32,
  parameter int ZERO_R0 = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stall_i,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_dest,
  input  logic [W_width-1:0]    req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_dest,
  input  logic [W_width-1:0]    req1_data,
  output logic                  req1_ready,
  output logic                  regWrite_o,
  output logic [REG_ADDR_W-1:0] destReg_o,
  output logic [W_width-1:0]    writeData_o,
  output logic                  grant_id_o,
  output logic                  dropped_o
);

  logic [1:0]         grant_s;
  logic               arb_en_s;
  logic               xfer_s;
  logic               win_id_s;
  reg_addr_t          win_dest_s;
  logic [W_width-1:0] win_data_s;
  logic               drop_s;

  logic               regWrite_q, regWrite_d;
  reg_addr_t          destReg_q, destReg_d;
  logic [W_width-1:0] writeData_q, writeData_d;
  logic               grant_id_q, grant_id_d;
  logic               dropped_q, dropped_d;

  // Readies must be low while reset is held, not just after the first edge
  assign arb_en_s = !RST && !stall_i;

  rr_arb2 u_arb (
    .clk_i    (CLK),
    .rst_i    (RST),
    .req_i    ({req1_valid, req0_valid}),
    .enable_i (arb_en_s),
    .grant_o  (grant_s)
  );

  assign req0_ready = grant_s[REQ_EXE];
  assign req1_ready = grant_s[REQ_LD];

  assign xfer_s     = |grant_s;
  assign win_id_s   = grant_s[REQ_LD];
  assign win_dest_s = win_id_s ? req1_dest : req0_dest;
  assign win_data_s = win_id_s ? req1_data : req0_data;
  assign drop_s     = (ZERO_R0 != 0) && (win_dest_s == R0);

  // Output stage next state: load on a transfer, otherwise hold data and idle
  always_comb begin
    regWrite_d  = 1'b0;
    dropped_d   = 1'b0;
    destReg_d   = destReg_q;
    writeData_d = writeData_q;
    grant_id_d  = grant_id_q;
    if (xfer_s) begin
      destReg_d   = win_dest_s;
      writeData_d = win_data_s;
      grant_id_d  = win_id_s;
      if (drop_s) begin
        dropped_d = 1'b1;
      end else begin
        regWrite_d = 1'b1;
      end
    end else begin
      regWrite_d = 1'b0;
      dropped_d  = 1'b0;
    end
  end

  // Output stage registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regWrite_q  <= 1'b0;
      destReg_q   <= 3'd0;
      writeData_q <= '0;
      grant_id_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      regWrite_q  <= regWrite_d;
      destReg_q   <= destReg_d;
      writeData_q <= writeData_d;
      grant_id_q  <= grant_id_d;
      dropped_q   <= dropped_d;
    end
  end

  assign regWrite_o  = regWrite_q;
  assign destReg_o   = destReg_q;
  assign writeData_o = writeData_q;
  assign grant_id_o  = grant_id_q;
  assign dropped_o   = dropped_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. Two instances share stimulus:
// dut (R0 writable) and dut_z (R0 writes suppressed).
module tb_rf_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall_i;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_dest, req1_dest;
  logic [31:0] req0_data, req1_data;

  logic        r0_rdy, r1_rdy, rw, gid, drp;
  logic [2:0]  dst;
  logic [31:0] wd;
  logic        z_r0_rdy, z_r1_rdy, z_rw, z_gid, z_drp;
  logic [2:0]  z_dst;
  logic [31:0] z_wd;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        xfer;
    logic        gid;
    logic [2:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic        m_prio;
  logic        h_gid;
  logic [2:0]  h_dest;
  logic [31:0] h_data;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(.W_width(32), .ZERO_R0(0)) dut (
    .CLK(CLK), .RST(RST), .stall_i(stall_i),
    .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data), .req0_ready(r0_rdy),
    .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data), .req1_ready(r1_rdy),
    .regWrite_o(rw), .destReg_o(dst), .writeData_o(wd), .grant_id_o(gid), .dropped_o(drp)
  );

  rf_write_arbiter #(.W_width(32), .ZERO_R0(1)) dut_z (
    .CLK(CLK), .RST(RST), .stall_i(stall_i),
    .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data), .req0_ready(z_r0_rdy),
    .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data), .req1_ready(z_r1_rdy),
    .regWrite_o(z_rw), .destReg_o(z_dst), .writeData_o(z_wd), .grant_id_o(z_gid), .dropped_o(z_drp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rw"}, rw, 1'b0);
    check({tag, "_dst"}, dst, 3'd0);
    check({tag, "_wd"}, wd, 32'd0);
    check({tag, "_gid"}, gid, 1'b0);
    check({tag, "_drp"}, drp, 1'b0);
    check({tag, "_z_rw"}, z_rw, 1'b0);
    check({tag, "_z_drp"}, z_drp, 1'b0);
  endtask

  // Called just after the active edge with inputs driven: check readies,
  // push the expected registered result, advance the model pointer.
  task automatic present(input string tag);
    exp_t e;
    logic e0, e1;
    #1;
    e0 = !stall_i && req0_valid && (!req1_valid || (m_prio == 1'b0));
    e1 = !stall_i && req1_valid && (!req0_valid || (m_prio == 1'b1));
    check({tag, "_rdy0"}, r0_rdy, e0);
    check({tag, "_rdy1"}, r1_rdy, e1);
    check({tag, "_z_rdy0"}, z_r0_rdy, e0);
    check({tag, "_z_rdy1"}, z_r1_rdy, e1);
    e.xfer = e0 | e1;
    e.gid  = e1;
    e.dest = e1 ? req1_dest : req0_dest;
    e.data = e1 ? req1_data : req0_data;
    sb_q.push_back(e);
    if (e0) m_prio = 1'b1;
    else if (e1) m_prio = 1'b0;
  endtask

  // Clock the transfer in and compare both output stages with the model.
  task automatic retire(input string tag);
    exp_t e;
    logic zdrop;
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      if (e.xfer) begin
        h_gid  = e.gid;
        h_dest = e.dest;
        h_data = e.data;
      end
      zdrop = e.xfer && (e.dest == 3'd0);
      check({tag, "_rw"}, rw, e.xfer);
      check({tag, "_drp"}, drp, 1'b0);
      check({tag, "_dst"}, dst, h_dest);
      check({tag, "_wd"}, wd, h_data);
      check({tag, "_gid"}, gid, h_gid);
      check({tag, "_z_rw"}, z_rw, e.xfer && !zdrop);
      check({tag, "_z_drp"}, z_drp, zdrop);
      check({tag, "_z_dst"}, z_dst, h_dest);
      check({tag, "_z_wd"}, z_wd, h_data);
      check({tag, "_z_gid"}, z_gid, h_gid);
    end
  endtask

  task automatic cycle(input string tag);
    present(tag);
    retire(tag);
  endtask

  task automatic drive(input logic v0, input logic [2:0] d0, input logic [31:0] x0,
                       input logic v1, input logic [2:0] d1, input logic [31:0] x1);
    req0_valid = v0; req0_dest = d0; req0_data = x0;
    req1_valid = v1; req1_dest = d1; req1_data = x1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_prio = 1'b0; h_gid = 1'b0; h_dest = 3'd0; h_data = 32'd0;
    RST = 1'b1; stall_i = 1'b0;
    // Valid during reset: readies must stay low
    drive(1'b1, 3'd4, 32'h4444_4444, 1'b1, 3'd6, 32'h6666_6666);
    #2;
    check("rst_rdy0", r0_rdy, 1'b0);
    check("rst_rdy1", r1_rdy, 1'b0);
    check_outputs_zero("rst");
    @(posedge CLK); @(posedge CLK);
    #1;
    check("rst_held_rdy0", r0_rdy, 1'b0);
    check_outputs_zero("rst_held");
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Idle after release
    cycle("idle0");
    cycle("idle1");

    // Lone req0
    drive(1'b1, 3'd5, 32'hDEAD_BEEF, 1'b0, 3'd0, 32'd0);
    cycle("lone0");
    // Lone req1 wins even though pointer now favours it anyway; pointer -> 0
    drive(1'b0, 3'd0, 32'd0, 1'b1, 3'd7, 32'h0000_0077);
    cycle("lone1");

    // Both valid for 4 cycles from prio=0: 0,1,0,1
    drive(1'b1, 3'd1, 32'h0000_0011, 1'b1, 3'd2, 32'h0000_0022);
    for (int i = 0; i < 4; i++) cycle($sformatf("alt%0d", i));

    // Stall 3 cycles with both valid; output stage drains
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("stall%0d", i));
    stall_i = 1'b0;
    cycle("post_stall0");
    cycle("post_stall1");

    // Lone req0 to move pointer to 1, then req1 write to R0
    drive(1'b1, 3'd3, 32'h0000_0033, 1'b0, 3'd0, 32'd0);
    cycle("pre_r0");
    drive(1'b0, 3'd0, 32'd0, 1'b1, 3'd0, 32'h0000_0055);
    cycle("r0_drop");
    // Pointer back at 0: req0 wins contention
    drive(1'b1, 3'd6, 32'h0000_0066, 1'b1, 3'd2, 32'h0000_00AA);
    cycle("after_drop0");
    // Same destination from both: winner now, loser next cycle
    drive(1'b1, 3'd4, 32'h0000_0A0A, 1'b1, 3'd4, 32'h0000_0B0B);
    cycle("same_dest0");
    drive(1'b1, 3'd4, 32'h0000_0A0A, 1'b0, 3'd0, 32'd0);
    cycle("same_dest1");
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    cycle("idle2");

    // Mid-operation reset right after a req0 transfer (pointer -> 1)
    drive(1'b1, 3'd5, 32'hCAFE_F00D, 1'b0, 3'd0, 32'd0);
    cycle("pre_rst");
    #2;
    RST = 1'b1;
    drive(1'b1, 3'd5, 32'hCAFE_F00D, 1'b1, 3'd2, 32'h0000_0222);
    #1;
    check("mid_rst_rdy0", r0_rdy, 1'b0);
    check("mid_rst_rdy1", r1_rdy, 1'b0);
    check_outputs_zero("mid_rst");
    sb_q.delete();
    m_prio = 1'b0; h_gid = 1'b0; h_dest = 3'd0; h_data = 32'd0;
    #2;
    RST = 1'b0;
    // Pointer reset to 0: re-presented req0 wins over req1
    cycle("re_present0");
    cycle("re_present1");
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    cycle("idle3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Two-requester write-port arbiter for register_file, which has 8 registers and a single write port (regWrite/destReg/writeData).
- Requester 0 is the execute unit; requester 1 is the load unit.
- Each requester uses a valid/ready handshake.
- The block picks one winner per cycle by round-robin and registers the winning write onto the register_file write port.
- Optionally drops writes to R0 and supports a global stall from the hazard controller.

Parameters:
W_width, 32, data width of writeData; must match register_file W_width.
ZERO_R0, 0, 1 = writes with dest 0 are accepted but suppressed (R0 hardwired zero); 0 = R0 is writable.

Ports:
CLK  input  1  clock; all state on rising edge.
RST  input  1  asynchronous, active-high reset.
stall_i  input  1  1 = grant nothing this cycle.
req0_valid  input  1  requester 0 has a write pending.
req0_dest  input  3  requester 0 destination register.
req0_data  input  W_width  requester 0 write data.
req0_ready  output  1  requester 0 write is accepted this cycle.
req1_valid  input  1  requester 1 has a write pending.
req1_dest  input  3  requester 1 destination register.
req1_data  input  W_width  requester 1 write data.
req1_ready  output  1  requester 1 write is accepted this cycle.
regWrite_o  output  1  to register_file regWrite.
destReg_o  output  3  to register_file destReg.
writeData_o  output  W_width  to register_file writeData.
grant_id_o  output  1  requester that produced the current regWrite_o/drop (0/1).
dropped_o  output  1  one-cycle pulse: an accepted write was suppressed by ZERO_R0.

Behaviour:
- Reset (RST high, asynchronous):
  - regWrite_o=0, destReg_o=0, writeData_o=0, grant_id_o=0, dropped_o=0.
  - Priority pointer prio=0 (requester 0 favoured).
  - req0_ready and req1_ready are forced 0 while RST is high.
- Reset asserted mid-operation: any registered but not-yet-clocked write is lost; requesters must hold their valid.
- Ready (combinational):
  - req0_ready = !RST & !stall_i & req0_valid & (!req1_valid | prio==0).
  - req1_ready = !RST & !stall_i & req1_valid & (!req0_valid | prio==1).
  - At most one ready is high per cycle.
  - Ready may depend on valid. Valid must not depend on ready.
- A transfer occurs when valid & ready. Requesters hold valid/dest/data stable until their transfer.
- Priority pointer: on a transfer by requester k, prio <= !k. No transfer leaves prio unchanged. A lone requester wins regardless of prio.
- Output stage, registered, 1-cycle latency from transfer to regWrite_o:
  - On a transfer: destReg_o, writeData_o and grant_id_o load the winner's values.
  - regWrite_o <= 1, except regWrite_o <= 0 and dropped_o <= 1 when ZERO_R0=1 and dest==0.
  - No transfer: regWrite_o <= 0, dropped_o <= 0; destReg_o, writeData_o and grant_id_o hold their last values.
- Throughput: one write per cycle sustained; back-to-back grants are allowed.
- Both requesters valid continuously: grants strictly alternate, so worst-case wait is 1 cycle (no starvation).
- stall_i: no grants and prio frozen. The output stage still drains (the write registered last cycle appears; the next cycle regWrite_o=0).
- Same dest from both requesters in one cycle: the winner writes first, the loser writes the next cycle. The final value is the loser's (program order is the requesters' responsibility).

Decomposition:
- Package rf_pkg:
  - REG_COUNT=8, REG_ADDR_W=3.
  - Requester id constants REQ_EXE=0, REQ_LD=1.
  - Register index constant R0=0.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], enable.
  - Outputs: grant[1:0] (one-hot or zero).
  - Owns the prio flop, with async active-high reset to 0.
- The top level holds the output register stage, the winner data mux and the ZERO_R0 suppression.

Test Plan:
- Reset, then idle -> all outputs 0, readies 0 during RST; after release with no valid, regWrite_o stays 0.
- req0 only, dest=5, data=0xDEADBEEF -> req0_ready=1 the same cycle; next cycle regWrite_o=1, destReg_o=5, writeData_o=0xDEADBEEF, grant_id_o=0.
- Both valid for 4 cycles (req0 dest=1/data=0x11, req1 dest=2/data=0x22), prio=0 -> grant order 0,1,0,1; regWrite_o=1 every cycle with dest 1,2,1,2.
- stall_i=1 for 3 cycles with both valid -> both readies 0, prio unchanged; after stall drops, the favoured requester is granted first.
- ZERO_R0=1, req1 dest=0, data=0x55 -> req1_ready=1; next cycle regWrite_o=0, dropped_o=1, grant_id_o=1; prio moves to 0.
- RST pulsed asynchronously mid-cycle right after a transfer -> regWrite_o clears immediately; prio=0 after release; the requester re-presents its write and it is granted.
